// File: rtl/btn_uart_arbiter.sv
// Latches button event pulses and shares one UART transmitter between them, round-robin.
// Optional `define BTN_ARB_OVF_EN adds a sticky overflow flag (o_overflow, cleared by i_ovf_clr).
//
// state       | meaning
// S_IDLE      | no transfer; grant next pending channel once TX is free
// S_WAIT_BUSY | start issued; waiting for TX busy to rise, bounded by BUSY_TMO cycles
// S_WAIT_DONE | TX shifting the byte out; waiting for busy to fall
module btn_uart_arbiter #(
   parameter int         N_BTN     = 4,
   parameter logic [7:0] BASE_CHAR = 8'h30,
   parameter int         BUSY_TMO  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] i_btn_pulse,
   input  logic             i_tx_busy,
   output logic             o_tx_start,
   output logic [7:0]       o_tx_data,
   output logic [N_BTN-1:0] o_grant,
   output logic [N_BTN-1:0] o_pending
`ifdef BTN_ARB_OVF_EN
   ,
   output logic             o_overflow,
   input  logic             i_ovf_clr
`endif
);
   localparam int PW = (N_BTN > 1) ? $clog2(N_BTN) : 1;
   localparam int CW = $clog2(BUSY_TMO + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE} state_t;

   state_t           state, state_nxt;
   logic [N_BTN-1:0] pending, pending_nxt, grant_nxt, clr_mask, sel_oh;
   logic [PW-1:0]    rr_ptr, rr_nxt, sel_idx, idx_w;
   logic [CW-1:0]    tmo_cnt, tmo_nxt;
   logic             start_nxt, found;
   logic [7:0]       data_nxt;
   int               idx;

   // Round-robin search: first pending bit at or after rr_ptr, wrapping.
   always_comb begin
      found   = 1'b0;
      sel_idx = '0;
      idx     = 0;
      idx_w   = '0;
      for (int k = 0; k < N_BTN; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N_BTN) idx = idx - N_BTN;
         idx_w = PW'(idx);
         if (!found && pending[idx_w]) begin
            found   = 1'b1;
            sel_idx = idx_w;
         end
      end
      sel_oh          = '0;
      sel_oh[sel_idx] = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = o_grant;
      start_nxt = 1'b0;
      data_nxt  = o_tx_data;
      rr_nxt    = rr_ptr;
      tmo_nxt   = tmo_cnt;
      clr_mask  = '0;
      case (state)
         S_IDLE: begin
            if (found && !i_tx_busy) begin
               clr_mask  = sel_oh;
               grant_nxt = sel_oh;
               data_nxt  = BASE_CHAR + 8'(sel_idx);
               start_nxt = 1'b1;
               rr_nxt    = (sel_idx == PW'(N_BTN - 1)) ? '0 : sel_idx + PW'(1);
               tmo_nxt   = CW'(BUSY_TMO);
               state_nxt = S_WAIT_BUSY;
            end
         end
         S_WAIT_BUSY: begin
            if (i_tx_busy) begin
               state_nxt = S_WAIT_DONE;
            end else if (tmo_cnt <= CW'(1)) begin
               // Busy never came: the byte is dropped, not re-queued.
               state_nxt = S_IDLE;
               grant_nxt = '0;
            end else begin
               tmo_nxt = tmo_cnt - CW'(1);
            end
         end
         S_WAIT_DONE: begin
            if (!i_tx_busy) begin
               state_nxt = S_IDLE;
               grant_nxt = '0;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            grant_nxt = '0;
         end
      endcase
      // A pulse arriving on the bit being granted re-arms it for a later send.
      pending_nxt = (pending & ~clr_mask) | i_btn_pulse;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= S_IDLE;
         pending    <= '0;
         o_grant    <= '0;
         rr_ptr     <= '0;
         o_tx_start <= 1'b0;
         o_tx_data  <= 8'h00;
         tmo_cnt    <= '0;
      end else begin
         state      <= state_nxt;
         pending    <= pending_nxt;
         o_grant    <= grant_nxt;
         rr_ptr     <= rr_nxt;
         o_tx_start <= start_nxt;
         o_tx_data  <= data_nxt;
         tmo_cnt    <= tmo_nxt;
      end
   end

   assign o_pending = pending;

`ifdef BTN_ARB_OVF_EN
   logic ovf_set;

   assign ovf_set = (|(i_btn_pulse & pending & ~clr_mask)) ||
                    ((state == S_WAIT_BUSY) && !i_tx_busy && (tmo_cnt <= CW'(1)));

   // Set beats clear when both happen in the same cycle.
   always_ff @(posedge clk) begin
      if (!reset)          o_overflow <= 1'b0;
      else if (ovf_set)    o_overflow <= 1'b1;
      else if (i_ovf_clr)  o_overflow <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_btn_uart_arbiter.sv
// Bench for btn_uart_arbiter: vector table for single-channel latency, scoreboard of sent bytes,
// and hand sequences for reset, busy hold, timeout, merge and same-cycle re-arm.
module tb_btn_uart_arbiter;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [N-1:0] i_btn_pulse = '0;
   logic         i_tx_busy = 1'b0;
   logic         o_tx_start;
   logic [7:0]   o_tx_data;
   logic [N-1:0] o_grant;
   logic [N-1:0] o_pending;
`ifdef BTN_ARB_OVF_EN
   logic         o_overflow;
   logic         i_ovf_clr = 1'b0;
`endif

   btn_uart_arbiter #(.N_BTN(N), .BASE_CHAR(8'h30), .BUSY_TMO(16)) dut (
      .clk(clk), .reset(reset), .i_btn_pulse(i_btn_pulse), .i_tx_busy(i_tx_busy),
      .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .o_grant(o_grant), .o_pending(o_pending)
`ifdef BTN_ARB_OVF_EN
      , .o_overflow(o_overflow), .i_ovf_clr(i_ovf_clr)
`endif
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // UART TX model: busy for 3 cycles starting in the start cycle, or forced by the test.
   logic force_busy = 1'b0;
   logic model_en = 1'b1;
   int   busy_cnt = 0;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (model_en && o_tx_start) busy_cnt = 3;
         else if (busy_cnt > 0) busy_cnt--;
         i_tx_busy = force_busy || (busy_cnt != 0);
      end
   end

   typedef struct { logic [7:0] data; logic [N-1:0] grant; } sb_t;
   sb_t exp_q[$];
   sb_t mon_e;
   logic prev_busy = 1'b0;

   always @(negedge clk) begin
      if (o_tx_start) begin
         check("start_after_free_cycle", 32'(prev_busy), 0);
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL sb_unexpected_start: got data %0h grant %0b, expected no start",
                     o_tx_data, o_grant);
         end else begin
            mon_e = exp_q.pop_front();
            check("sb_data", 32'(o_tx_data), 32'(mon_e.data));
            check("sb_grant", 32'(o_grant), 32'(mon_e.grant));
         end
      end
      prev_busy = i_tx_busy;
   end

   task automatic wait_idle();
      int n = 0;
      while ((o_grant != '0 || i_tx_busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("wait_idle_bound", 32'(n < 200), 1);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain_queue_empty", 32'(exp_q.size()), 0);
      wait_idle();
   endtask

   typedef struct {
      logic [N-1:0] pulse;
      logic [N-1:0] exp_pend;
      logic [7:0]   exp_data;
      logic [N-1:0] exp_grant;
   } vec_t;
   vec_t vecs[4];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   int starts;

   initial begin
      vecs[0] = '{4'b0100, 4'b0100, 8'h32, 4'b0100};
      vecs[1] = '{4'b0001, 4'b0001, 8'h30, 4'b0001};
      vecs[2] = '{4'b1000, 4'b1000, 8'h33, 4'b1000};
      vecs[3] = '{4'b0010, 4'b0010, 8'h31, 4'b0010};

      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst0_start", 32'(o_tx_start), 0);
      check("rst0_data", 32'(o_tx_data), 0);
      check("rst0_grant", 32'(o_grant), 0);
      check("rst0_pend", 32'(o_pending), 0);
`ifdef BTN_ARB_OVF_EN
      check("rst0_ovf", 32'(o_overflow), 0);
`endif
      reset = 1'b1;
      @(negedge clk);

      // Single channel: pending at t+1, start/data/grant at t+2.
      for (int i = 0; i < 4; i++) begin
         wait_idle();
         exp_q.push_back('{vecs[i].exp_data, vecs[i].exp_grant});
         i_btn_pulse = vecs[i].pulse;
         @(negedge clk);
         i_btn_pulse = '0;
         check($sformatf("vec%0d_pend", i), 32'(o_pending), 32'(vecs[i].exp_pend));
         @(negedge clk);
         check($sformatf("vec%0d_start", i), 32'(o_tx_start), 1);
         check($sformatf("vec%0d_data", i), 32'(o_tx_data), 32'(vecs[i].exp_data));
         check($sformatf("vec%0d_grant", i), 32'(o_grant), 32'(vecs[i].exp_grant));
         check($sformatf("vec%0d_pend_clr", i), 32'(o_pending), 0);
      end
      drain();

      // Reset with events pending (rr_ptr is 2 here), then same three events from ch0.
      force_busy = 1'b1;
      @(negedge clk);
      @(negedge clk);
      i_btn_pulse = 4'b1011;
      @(negedge clk);
      i_btn_pulse = '0;
      check("held_pend", 32'(o_pending), 32'(4'b1011));
      reset = 1'b0;
      @(negedge clk);
      check("rst1_start", 32'(o_tx_start), 0);
      check("rst1_data", 32'(o_tx_data), 0);
      check("rst1_grant", 32'(o_grant), 0);
      check("rst1_pend", 32'(o_pending), 0);
      reset = 1'b1;
      force_busy = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("post_rst_pend", 32'(o_pending), 0);
      exp_q.push_back('{8'h30, 4'b0001});
      exp_q.push_back('{8'h31, 4'b0010});
      exp_q.push_back('{8'h33, 4'b1000});
      i_btn_pulse = 4'b1011;
      @(negedge clk);
      i_btn_pulse = '0;
      drain();

      // Busy held: event waits, start one cycle after busy falls.
      force_busy = 1'b1;
      @(negedge clk);
      @(negedge clk);
      i_btn_pulse = 4'b0010;
      @(negedge clk);
      i_btn_pulse = '0;
      starts = 0;
      repeat (6) begin
         if (o_tx_start) starts++;
         @(negedge clk);
      end
      check("busy_hold_nostart", 32'(starts), 0);
      check("busy_hold_pend", 32'(o_pending), 32'(4'b0010));
      exp_q.push_back('{8'h31, 4'b0010});
      force_busy = 1'b0;
      @(negedge clk);
      check("rel_nostart", 32'(o_tx_start), 0);
      @(negedge clk);
      check("rel_start", 32'(o_tx_start), 1);
      check("rel_data", 32'(o_tx_data), 32'(8'h31));
      drain();

      // TX never answers: WAIT_BUSY lasts 16 cycles, then back to idle.
      model_en = 1'b0;
      exp_q.push_back('{8'h33, 4'b1000});
      i_btn_pulse = 4'b1000;
      @(negedge clk);
      i_btn_pulse = '0;
      @(negedge clk);
      check("tmo_start", 32'(o_tx_start), 1);
      repeat (15) @(negedge clk);
      check("tmo_grant_held", 32'(o_grant), 32'(4'b1000));
`ifdef BTN_ARB_OVF_EN
      check("tmo_ovf_before", 32'(o_overflow), 0);
`endif
      @(negedge clk);
      check("tmo_grant_drop", 32'(o_grant), 0);
      check("tmo_pend", 32'(o_pending), 0);
`ifdef BTN_ARB_OVF_EN
      check("tmo_ovf_set", 32'(o_overflow), 1);
      repeat (3) @(negedge clk);
      check("tmo_ovf_sticky", 32'(o_overflow), 1);
      i_ovf_clr = 1'b1;
      @(negedge clk);
      i_ovf_clr = 1'b0;
      check("tmo_ovf_clr", 32'(o_overflow), 0);
`endif
      model_en = 1'b1;
      drain();

      // Two pulses on an already pending ch1 merge into a single send.
      force_busy = 1'b1;
      @(negedge clk);
      @(negedge clk);
      exp_q.push_back('{8'h31, 4'b0010});
      i_btn_pulse = 4'b0010;
      @(negedge clk);
      check("merge_pend1", 32'(o_pending), 32'(4'b0010));
      @(negedge clk);
      i_btn_pulse = '0;
      check("merge_pend2", 32'(o_pending), 32'(4'b0010));
`ifdef BTN_ARB_OVF_EN
      check("merge_ovf", 32'(o_overflow), 1);
      i_ovf_clr = 1'b1;
      @(negedge clk);
      i_ovf_clr = 1'b0;
      check("merge_ovf_clr", 32'(o_overflow), 0);
`endif
      force_busy = 1'b0;
      drain();

      // Pulse on ch0 in the very cycle ch0 is granted: the new event survives.
      force_busy = 1'b1;
      @(negedge clk);
      @(negedge clk);
      i_btn_pulse = 4'b0001;
      @(negedge clk);
      i_btn_pulse = '0;
      exp_q.push_back('{8'h30, 4'b0001});
      exp_q.push_back('{8'h30, 4'b0001});
      force_busy = 1'b0;
      @(negedge clk);
      i_btn_pulse = 4'b0001;
      @(negedge clk);
      i_btn_pulse = '0;
      check("rearm_start", 32'(o_tx_start), 1);
      check("rearm_pend", 32'(o_pending), 32'(4'b0001));
`ifdef BTN_ARB_OVF_EN
      check("rearm_ovf", 32'(o_overflow), 0);
`endif
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
